// File: rtl/mc_pkg.sv
// Shared types for the memory-controller request arbiter.
// The two arbiter states: free round-robin versus burst lock on an owner.
package mc_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mc_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request found scanning upward from start, wrapping modulo N_REQ.
module mc_rr_pick
    import mc_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // start is always below N_REQ, so the modulo keeps non-power-of-two counts in range
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[(int'(start) + k) % N_REQ]) begin
                any                                  = 1'b1;
                idx                                  = ID_W'((int'(start) + k) % N_REQ);
                grant[(int'(start) + k) % N_REQ]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_req_arb.sv
// Round-robin arbiter with burst locking in front of the memory-controller command port.
// Pops at most one requester FIFO per cycle into a registered command stage.
module mc_req_arb
    import mc_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [N_REQ-1:0]       req_vld_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_pop_o,
    output logic                   cmd_vld_o,
    output logic [WIDTH-1:0]       cmd_data_o,
    output logic [ID_W-1:0]        cmd_id_o,
    input  logic                   cmd_rdy_i,
    output logic                   busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W-1:0]  start;
    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             stay;
    logic             load;
    logic [ID_W-1:0]  winner;
    logic [WIDTH-1:0] win_data;

    // Scan begins just past the owner so the owner itself is considered last
    assign start = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    mc_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req_vld_i),
        .start (start),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign stay   = (state_q == ARB_LOCK) && req_vld_i[owner_q] && (cnt_q < CNT_W'(MAX_BURST));
    assign winner = stay ? owner_q : pick_idx;
    assign load   = (~cmd_vld_o | cmd_rdy_i) & pick_any;
    assign busy_o = cmd_vld_o | (|req_vld_i);

    always_comb begin
        req_pop_o = '0;
        if (rst_n_i && load) begin
            if (stay) begin
                req_pop_o[owner_q] = 1'b1;
            end else begin
                req_pop_o = pick_grant;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                win_data = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            owner_q <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // A re-grant after exhaustion comes through the picker, so it restarts the count at 1
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = ARB_LOCK;
            if (stay) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d   = CNT_W'(1);
                owner_d = winner;
            end
        end else if (!pick_any) begin
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_vld_o  <= 1'b0;
            cmd_data_o <= '0;
            cmd_id_o   <= '0;
        end else if (load) begin
            cmd_vld_o  <= 1'b1;
            cmd_data_o <= win_data;
            cmd_id_o   <= winner;
        end else if (cmd_rdy_i) begin
            cmd_vld_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_req_arb.sv
// Self-checking bench for mc_req_arb: directed scenarios plus a randomized run
// compared every cycle against a queue-level arbitration model.
module tb_mc_req_arb;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_pop;
    logic                   cmd_vld;
    logic [WIDTH-1:0]       cmd_data;
    logic [1:0]             cmd_id;
    logic                   cmd_rdy;
    logic                   busy;

    int vectors;
    int miscompares;

    // Model of the arbiter in terms of owner, grant streak and the held command
    int          m_owner;
    int          m_cnt;
    bit          m_locked;
    bit          m_vld;
    logic [31:0] m_data;
    int          m_id;

    mc_req_arb #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_vld_i  (req_vld),
        .req_data_i (req_data),
        .req_pop_o  (req_pop),
        .cmd_vld_o  (cmd_vld),
        .cmd_data_o (cmd_data),
        .cmd_id_o   (cmd_id),
        .cmd_rdy_i  (cmd_rdy),
        .busy_o     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic r, input logic [31:0] base);
        @(posedge clk);
        #1;
        req_vld = v;
        cmd_rdy = r;
        for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = base + 32'(i);
        #1;
    endtask

    task automatic doReset();
        req_vld  = '0;
        req_data = '0;
        cmd_rdy  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int modelWinner(input logic [3:0] v);
        if (m_locked && v[m_owner] && m_cnt < MAX_BURST) return m_owner;
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(m_owner + k) % N_REQ]) return (m_owner + k) % N_REQ;
        end
        return -1;
    endfunction

    // Compare process: check outputs mid-cycle, then advance the model past the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owner  = N_REQ - 1;
                m_cnt    = 0;
                m_locked = 0;
                m_vld    = 0;
                m_data   = '0;
                m_id     = 0;
                checkOutput("rst_pop", 32'(req_pop), 32'd0);
                checkOutput("rst_vld", 32'(cmd_vld), 32'd0);
                checkOutput("rst_data", cmd_data, 32'd0);
                checkOutput("rst_id", 32'(cmd_id), 32'd0);
            end else begin
                bit          any;
                bit          load;
                int          w;
                logic [31:0] exp_pop;
                any     = |req_vld;
                load    = (!m_vld || cmd_rdy) && any;
                w       = modelWinner(req_vld);
                exp_pop = load ? (32'd1 << w) : 32'd0;
                checkOutput("pop", 32'(req_pop), exp_pop);
                checkOutput("cmd_vld", 32'(cmd_vld), 32'(m_vld));
                if (m_vld) begin
                    checkOutput("cmd_data", cmd_data, m_data);
                    checkOutput("cmd_id", 32'(cmd_id), 32'(m_id));
                end
                checkOutput("busy", 32'(busy), 32'(m_vld || any));
                if (load) begin
                    if (m_locked && w == m_owner && req_vld[m_owner] && m_cnt < MAX_BURST) begin
                        m_cnt++;
                    end else begin
                        m_cnt   = 1;
                        m_owner = w;
                    end
                    m_locked = 1;
                    m_vld    = 1;
                    m_data   = req_data[w*WIDTH +: WIDTH];
                    m_id     = w;
                end else begin
                    if (cmd_rdy) m_vld = 0;
                    if (!any) m_locked = 0;
                end
            end
        end
    end

    initial begin
        int burst_ids[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        int resume_ids[4] = '{0, 0, 0, 1};
        vectors     = 0;
        miscompares = 0;

        // Single requester: continuous re-grant with no bubbles
        doReset();
        applyStimulus(4'b0001, 1'b1, 32'h1000_0000);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0001, 1'b1, 32'h1000_0000 + 32'(i * 16));
            checkOutput("single_vld", 32'(cmd_vld), 32'd1);
            checkOutput("single_id", 32'(cmd_id), 32'd0);
        end

        // Burst limit with all requesters valid
        doReset();
        applyStimulus(4'b1111, 1'b1, 32'h2000_0000);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b1111, 1'b1, 32'h2000_0000 + 32'(i * 16));
            checkOutput("burst_id", 32'(cmd_id), 32'(burst_ids[i]));
        end

        // Owner 1 drops out mid-burst
        doReset();
        applyStimulus(4'b0010, 1'b1, 32'h3000_0000);
        applyStimulus(4'b0010, 1'b1, 32'h3000_0010);
        checkOutput("drop_id_a", 32'(cmd_id), 32'd1);
        applyStimulus(4'b1001, 1'b1, 32'h3000_0020);
        checkOutput("drop_id_b", 32'(cmd_id), 32'd1);
        applyStimulus(4'b0000, 1'b1, 32'h3000_0030);
        checkOutput("drop_id_next", 32'(cmd_id), 32'd3);
        checkOutput("drop_data_next", cmd_data, 32'h3000_0023);

        // Backpressure holds the register and blocks pops
        doReset();
        applyStimulus(4'b1111, 1'b1, 32'hCAFE_0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 1'b0, 32'h1111_0000);
            checkOutput("bp_pop", 32'(req_pop), 32'd0);
            checkOutput("bp_data", cmd_data, 32'hCAFE_0000);
            checkOutput("bp_id", 32'(cmd_id), 32'd0);
        end
        applyStimulus(4'b1111, 1'b1, 32'h2222_0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1111, 1'b1, 32'h3333_0000);
            checkOutput("resume_vld", 32'(cmd_vld), 32'd1);
            checkOutput("resume_id", 32'(cmd_id), 32'(resume_ids[i]));
            if (i == 0) checkOutput("resume_data", cmd_data, 32'h2222_0000);
        end

        // Idle gap releases the lock; round-robin resumes after owner 2
        doReset();
        applyStimulus(4'b0100, 1'b1, 32'h4000_0000);
        applyStimulus(4'b0000, 1'b1, 32'h4000_0010);
        checkOutput("idle_id_first", 32'(cmd_id), 32'd2);
        applyStimulus(4'b0000, 1'b1, 32'h4000_0020);
        applyStimulus(4'b0000, 1'b1, 32'h4000_0030);
        applyStimulus(4'b1111, 1'b1, 32'h4000_0040);
        applyStimulus(4'b0000, 1'b1, 32'h4000_0050);
        checkOutput("idle_id_after", 32'(cmd_id), 32'd3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), $urandom);
        end

        // Asynchronous reset mid-stream
        applyStimulus(4'b1111, 1'b1, 32'h5000_0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_vld", 32'(cmd_vld), 32'd0);
        checkOutput("async_pop", 32'(req_pop), 32'd0);
        checkOutput("async_id", 32'(cmd_id), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1, 32'h6000_0000);
        applyStimulus(4'b0000, 1'b1, 32'h6000_0010);
        checkOutput("post_rst_id", 32'(cmd_id), 32'd0);
        checkOutput("post_rst_data", cmd_data, 32'h6000_0000);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
